// File: rtl/opti_sos_sched.sv
// Time-multiplexing scheduler for one shared biquad engine: walks one sample through every section in turn.
// Latency: accept at t -> out_valid at t+2+NUM_SECTIONS*(L+1) for engine latency L; back-to-back period N*(L+1)+2.
// Backpressure: single-entry hold register; in_ready low while it is full or during flush. Output has no backpressure.
// Optional: OPTI_SCHED_STATS_EN adds sample_cnt / drop_cnt statistics ports.
module opti_sos_sched #(
   parameter int DATA_W       = 16,
   parameter int NUM_SECTIONS = 5,
   parameter int SEC_W        = 3,
   parameter int TIMEOUT      = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              flush,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              eng_start,
   output logic [SEC_W-1:0]  eng_sec,
   output logic [DATA_W-1:0] eng_x,
   output logic              eng_clear,
   input  logic              eng_done,
   input  logic [DATA_W-1:0] eng_y,
   output logic              busy,
`ifdef OPTI_SCHED_STATS_EN
   output logic [15:0]       sample_cnt,
   output logic [7:0]        drop_cnt,
`endif
   output logic              err_timeout
);

   localparam int WCNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_EMIT, ST_CLEAR} state_t;

   state_t              state, state_nxt;
   logic                hold_full;
   logic [DATA_W-1:0]   hold_data;
   logic [DATA_W-1:0]   cur;
   logic [DATA_W-1:0]   out_q;
   logic [SEC_W-1:0]    sec;
   logic [WCNT_W-1:0]   wcnt;
   logic                accept;
   logic                last_sec;
   logic                timeout_hit;
   logic                load;
   logic                timeout_abort;

   assign in_ready      = ~hold_full & ~flush;
   assign accept        = in_valid & in_ready;
   assign last_sec      = (sec == SEC_W'(NUM_SECTIONS - 1));
   assign timeout_hit   = (wcnt == WCNT_W'(TIMEOUT - 1));
   // Loading the held sample and declaring a timeout both yield to flush.
   assign load          = (state == ST_IDLE) & hold_full & ~flush;
   assign timeout_abort = (state == ST_WAIT) & ~eng_done & timeout_hit & ~flush;

   assign eng_sec  = sec;
   assign eng_x    = cur;
   assign out_data = out_q;
   assign busy     = (state != ST_IDLE);

   // Next-state and one-cycle strobes; flush overrides every state.
   always_comb begin
      state_nxt = state;
      eng_start = 1'b0;
      eng_clear = 1'b0;
      out_valid = 1'b0;
      case (state)
         ST_IDLE:  if (hold_full) state_nxt = ST_ISSUE;
         ST_ISSUE: begin
            eng_start = 1'b1;
            state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (eng_done)         state_nxt = last_sec ? ST_EMIT : ST_ISSUE;
            else if (timeout_hit) state_nxt = ST_CLEAR;
         end
         ST_EMIT: begin
            out_valid = 1'b1;
            state_nxt = ST_IDLE;
         end
         ST_CLEAR: begin
            eng_clear = 1'b1;
            state_nxt = ST_IDLE;
         end
         default:  state_nxt = ST_IDLE;
      endcase
      if (flush) state_nxt = ST_CLEAR;
   end

   // State register, hold slot, running section value and timeout watchdog.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         hold_full   <= 1'b0;
         hold_data   <= '0;
         cur         <= '0;
         out_q       <= '0;
         sec         <= '0;
         wcnt        <= '0;
         err_timeout <= 1'b0;
      end else begin
         state <= state_nxt;
         if (flush || load) begin
            hold_full <= 1'b0;
         end else if (accept) begin
            hold_full <= 1'b1;
            hold_data <= in_data;
         end
         if (load) begin
            cur <= hold_data;
            sec <= '0;
         end
         if (state == ST_ISSUE) wcnt <= '0;
         if (state == ST_WAIT) begin
            if (eng_done) begin
               cur <= eng_y;
               if (!last_sec) sec <= sec + SEC_W'(1);
               else if (!flush) out_q <= eng_y;
            end else if (!timeout_hit) begin
               wcnt <= wcnt + WCNT_W'(1);
            end
         end
         if (timeout_abort) err_timeout <= 1'b1;
      end
   end

`ifdef OPTI_SCHED_STATS_EN
   logic [1:0] drop_inc;
   logic [8:0] drop_sum;

   // Samples lost this cycle: in-flight and/or held sample on flush, or the live one on timeout.
   always_comb begin
      drop_inc = 2'd0;
      if (flush)
         drop_inc = 2'({1'b0, (state == ST_ISSUE) || (state == ST_WAIT)}) + 2'({1'b0, hold_full});
      else if (timeout_abort)
         drop_inc = 2'd1;
   end

   assign drop_sum = {1'b0, drop_cnt} + {7'd0, drop_inc};

   // Emitted-sample counter wraps; drop counter saturates at 255.
   always_ff @(posedge clk) begin
      if (rst) begin
         sample_cnt <= '0;
         drop_cnt   <= '0;
      end else begin
         if (state == ST_EMIT) sample_cnt <= sample_cnt + 16'd1;
         drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      end
   end
`endif

endmodule

// File: tb/tb_opti_sos_sched.sv
// Self-checking bench for opti_sos_sched: engine model with done 2 cycles after start and y = x + 1,
// a timing/value scoreboard derived from the latency rules, then directed timeout, flush and reset cases.
module tb_opti_sos_sched;
   localparam int NSEC = 5;

   logic        clk, rst;
   logic [15:0] in_data;
   logic        in_valid, in_ready, flush;
   logic [15:0] out_data;
   logic        out_valid, eng_start, eng_clear, eng_done, busy, err_timeout;
   logic [2:0]  eng_sec;
   logic [15:0] eng_x, eng_y;
`ifdef OPTI_SCHED_STATS_EN
   logic [15:0] sample_cnt;
   logic [7:0]  drop_cnt;
`endif

   opti_sos_sched dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .flush(flush), .out_data(out_data), .out_valid(out_valid), .eng_start(eng_start),
      .eng_sec(eng_sec), .eng_x(eng_x), .eng_clear(eng_clear), .eng_done(eng_done),
      .eng_y(eng_y), .busy(busy),
`ifdef OPTI_SCHED_STATS_EN
      .sample_cnt(sample_cnt), .drop_cnt(drop_cnt),
`endif
      .err_timeout(err_timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Engine model: result one cycle-pair after the start pulse, y = x + 1.
   logic        eng_en = 1'b1;
   int          pend = 0;
   logic [15:0] ex = '0;
   initial begin
      eng_done = 1'b0;
      eng_y    = '0;
      forever begin
         @(posedge clk); #1;
         eng_done = 1'b0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               eng_done = 1'b1;
               eng_y    = ex + 16'd1;
            end
         end
         @(negedge clk);
         if (eng_start && eng_en) begin
            pend = 2;
            ex   = eng_x;
         end
      end
   end

   // Reference model: each sample leaves as x + NSEC; the hold loads at max(accept+1, prev emit+1),
   // and output follows 16 cycles after the load.
   typedef struct { logic [15:0] d; int emit; } exp_t;
   exp_t exp_q[$];
   logic mon_en = 1'b0;
   int   hold_acc = -1, hold_load = -1, last_emit = -100, start_idx = 0;
   int   clr_cnt = 0, ov_cnt = 0, clr_cyc = -1;

   always @(negedge clk) begin
      if (eng_clear) begin
         clr_cnt++;
         clr_cyc = cyc;
      end
      if (out_valid) ov_cnt++;
      if (mon_en && !rst) begin
         if (!flush)
            check_eq("in_ready", in_ready, !(cyc > hold_acc && cyc <= hold_load));
         if (eng_start) begin
            check_eq("start_has_sample", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               check_eq("eng_sec", eng_sec, start_idx);
               check_eq("eng_x", eng_x, exp_q[0].d + 16'(start_idx));
            end
            start_idx++;
         end
         if (out_valid) begin
            check_eq("out_has_sample", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               exp_t e;
               e = exp_q.pop_front();
               check_eq("out_data", out_data, e.d + 16'(NSEC));
               check_eq("out_cycle", cyc, e.emit);
            end
            start_idx = 0;
         end
         if (in_valid && in_ready) begin
            exp_t e;
            int ld;
            ld        = (cyc + 1 > last_emit + 1) ? cyc + 1 : last_emit + 1;
            e.d       = in_data;
            e.emit    = ld + 16;
            last_emit = e.emit;
            hold_acc  = cyc;
            hold_load = ld;
            exp_q.push_back(e);
         end
      end
   end

   int acc_cyc;

   // Present one sample until accepted (bounded); returns at posedge+1 after the accepting edge.
   task automatic send(input logic [15:0] d);
      int n;
      in_data  = d;
      in_valid = 1'b1;
      for (n = 0; n < 200; n++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      check_eq("send_accepted", n < 200, 1);
      acc_cyc = cyc;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      for (n = 0; n < 400; n++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !busy) break;
      end
      check_eq("drain_empty", exp_q.size(), 0);
      @(posedge clk); #1;
   endtask

   task automatic wait_start_sec(input int s);
      int n;
      for (n = 0; n < 200; n++) begin
         @(negedge clk);
         if (eng_start && eng_sec == 3'(s)) break;
      end
      check_eq("reach_section", n < 200, 1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic restart_model();
      exp_q.delete();
      start_idx = 0;
      mon_en    = 1'b1;
   endtask

   int c0, o0;

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_eq("rst_in_ready", in_ready, 1);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_eng_start", eng_start, 0);
      check_eq("rst_eng_clear", eng_clear, 0);
      check_eq("rst_err", err_timeout, 0);
      check_eq("rst_out_data", out_data, 0);
      @(posedge clk); #1;

      // Single sample and a back-to-back pair through the scoreboard.
      restart_model();
      send(16'h4000);
      drain();
      check_eq("t1_out_data", out_data, 16'h4005);
      send(16'h0100);
      send(16'h0200);
      drain();
      check_eq("t2_out_data", out_data, 16'h0205);

      // Random samples with random gaps, including zero gaps.
      for (int i = 0; i < 20; i++) begin
         idle($urandom_range(0, 20));
         send(16'($urandom));
      end
      drain();

      // Engine never answers: watchdog abort.
      mon_en = 1'b0;
      eng_en = 1'b0;
      c0 = clr_cnt; o0 = ov_cnt;
      send(16'h1234);
      idle(30);
      check_eq("t3_clear_count", clr_cnt - c0, 1);
      check_eq("t3_clear_cycle", clr_cyc, acc_cyc + 18);
      check_eq("t3_no_out", ov_cnt - o0, 0);
      check_eq("t3_err", err_timeout, 1);
      check_eq("t3_idle", busy, 0);
      eng_en = 1'b1;
      restart_model();
      send(16'h0010);
      drain();
      check_eq("t3_recover_data", out_data, 16'h0015);
      check_eq("t3_err_sticky", err_timeout, 1);

      // Flush during section 2 with a second sample waiting in the hold.
      mon_en = 1'b0;
      c0 = clr_cnt; o0 = ov_cnt;
      send(16'h0300);
      send(16'h0400);
      wait_start_sec(2);
      check_eq("t4_held", in_ready, 0);
      @(posedge clk); #1 flush = 1'b1;
      @(negedge clk);
      check_eq("t4_ready_flush", in_ready, 0);
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      check_eq("t4_clear", eng_clear, 1);
      idle(40);
      check_eq("t4_clear_count", clr_cnt - c0, 1);
      check_eq("t4_no_out", ov_cnt - o0, 0);
      check_eq("t4_ready", in_ready, 1);
      check_eq("t4_idle", busy, 0);

      // Reset while waiting on section 3; the late done must be ignored.
      c0 = clr_cnt; o0 = ov_cnt;
      send(16'h0500);
      wait_start_sec(3);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check_eq("t5_busy", busy, 0);
      check_eq("t5_eng_sec", eng_sec, 0);
      check_eq("t5_eng_x", eng_x, 0);
      check_eq("t5_out_data", out_data, 0);
      check_eq("t5_err", err_timeout, 0);
      check_eq("t5_ready", in_ready, 1);
      idle(30);
      check_eq("t5_no_out", ov_cnt - o0, 0);
      check_eq("t5_no_clear", clr_cnt - c0, 0);
      check_eq("t5_still_idle", busy, 0);
`ifdef OPTI_SCHED_STATS_EN
      check_eq("t6_cnt_reset", sample_cnt, 0);
`endif

      // Three good samples then one timeout.
      restart_model();
      for (int i = 0; i < 3; i++) send(16'($urandom));
      drain();
      mon_en = 1'b0;
      eng_en = 1'b0;
      send(16'h0777);
      idle(30);
      eng_en = 1'b1;
      check_eq("t6_err", err_timeout, 1);
`ifdef OPTI_SCHED_STATS_EN
      check_eq("t6_sample_cnt", sample_cnt, 3);
      check_eq("t6_drop_cnt", drop_cnt, 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
